// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite streaming block.
// Holds the FSM state encoding, the scale selector type and the repeat-count helper.
package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        LOAD   = 2'd2
    } state_e;

    typedef logic [1:0] scale_t;

    localparam int MAX_SCALE = 8;
    localparam int SCALE_W   = $clog2(MAX_SCALE);

    // Last value of a repeat counter for a repeat factor of 1<<s.
    function automatic logic [SCALE_W-1:0] scale_last(input scale_t s);
        return SCALE_W'((1 << s) - 1);
    endfunction

endpackage

// File: rtl/sprite_mem.sv
// Sprite bitmap storage: flop array that reverts to INIT on reset,
// one synchronous write port (linear index) and one combinational read port.
module sprite_mem #(
    parameter int                           WIDTH  = 12,
    parameter int                           HEIGHT = 12,
    parameter int                           BPP    = 2,
    parameter logic [WIDTH*HEIGHT*BPP-1:0]  INIT   = '0,
    parameter int                           AW     = $clog2(WIDTH*HEIGHT)
) (
    input  logic           gclk,
    input  logic           rst_ni,
    input  logic           wr_en,
    input  logic [AW-1:0]  wr_addr,
    input  logic [BPP-1:0] wr_data,
    input  logic [AW-1:0]  rd_addr,
    output logic [BPP-1:0] rd_data
);

    localparam int NPIX = WIDTH * HEIGHT;

    logic [BPP-1:0] cells_reg [NPIX];

    always_ff @(posedge gclk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NPIX; i++) begin
                cells_reg[i] <= INIT[i*BPP +: BPP];
            end
        end else if (wr_en) begin
            cells_reg[wr_addr] <= wr_data;
        end
    end

    // Addresses are always formed from in-range x/y, so no bounds guard is needed.
    assign rd_data = cells_reg[rd_addr];

endmodule

// File: rtl/sprite_stream.sv
// Streams a WIDTH x HEIGHT sprite one screen pixel per pix_en beat, with
// horizontal mirroring, power-of-two X/Y upscaling and a valid/ready bitmap reload port.
module sprite_stream
    import sprite_pkg::*;
#(
    parameter int                           WIDTH  = 12,
    parameter int                           HEIGHT = 12,
    parameter int                           BPP    = 2,
    parameter logic [WIDTH*HEIGHT*BPP-1:0]  INIT   = '0
) (
    input  logic           gclk,
    input  logic           rst_ni,
    input  logic           pix_en,
    input  logic           line_start,
    input  logic           frame_start,
    input  logic           hmirror,
    input  logic [1:0]     xscale,
    input  logic [1:0]     yscale,
    input  logic           load_start,
    input  logic           load_valid,
    input  logic [BPP-1:0] load_data,
    output logic           load_ready,
    output logic           load_done,
    output logic [BPP-1:0] pixel_o,
    output logic           pixel_vld_o,
    output logic           frame_done_o
);

    localparam int NPIX = WIDTH * HEIGHT;
    localparam int XW   = $clog2(WIDTH);
    localparam int YW   = $clog2(HEIGHT);
    localparam int AW   = $clog2(NPIX);

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
    localparam logic [AW-1:0] P_LAST = AW'(NPIX - 1);
    localparam logic [AW-1:0] ROW_W  = AW'(WIDTH);

    state_e               state_reg;
    logic [XW-1:0]        x_reg;
    logic [YW-1:0]        y_reg;
    logic [SCALE_W-1:0]   sx_reg;
    logic [SCALE_W-1:0]   sy_reg;
    logic [AW-1:0]        wptr_reg;
    logic                 mirror_reg;
    scale_t               xs_reg;
    scale_t               ys_reg;
    logic                 load_done_reg;
    logic                 frame_done_reg;

    logic                 wr_en;
    logic [AW-1:0]        rd_addr;
    logic [BPP-1:0]       rd_pixel;
    logic [XW-1:0]        x_end;

    assign wr_en   = (state_reg == LOAD) && load_valid && !load_start;
    assign rd_addr = AW'(y_reg) * ROW_W + AW'(x_reg);
    assign x_end   = mirror_reg ? '0 : X_LAST;

    sprite_mem #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .BPP    (BPP),
        .INIT   (INIT),
        .AW     (AW)
    ) u_mem (
        .gclk    (gclk),
        .rst_ni  (rst_ni),
        .wr_en   (wr_en),
        .wr_addr (wptr_reg),
        .wr_data (load_data),
        .rd_addr (rd_addr),
        .rd_data (rd_pixel)
    );

    always_ff @(posedge gclk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= IDLE;
            x_reg          <= '0;
            y_reg          <= '0;
            sx_reg         <= '0;
            sy_reg         <= '0;
            wptr_reg       <= '0;
            mirror_reg     <= 1'b0;
            xs_reg         <= '0;
            ys_reg         <= '0;
            load_done_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            load_done_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            if (load_start) begin
                state_reg <= LOAD;
                wptr_reg  <= '0;
            end else if (state_reg == LOAD) begin
                if (load_valid) begin
                    if (wptr_reg == P_LAST) begin
                        state_reg     <= IDLE;
                        wptr_reg      <= '0;
                        load_done_reg <= 1'b1;
                        y_reg         <= '0;
                        sy_reg        <= '0;
                    end else begin
                        wptr_reg <= wptr_reg + 1'b1;
                    end
                end
            end else if (frame_start || line_start) begin
                // Rewind is applied first so a simultaneous line_start begins at row 0.
                if (frame_start) begin
                    state_reg <= IDLE;
                    y_reg     <= '0;
                    sy_reg    <= '0;
                    ys_reg    <= yscale;
                end
                if (line_start) begin
                    state_reg  <= ACTIVE;
                    x_reg      <= hmirror ? X_LAST : '0;
                    sx_reg     <= '0;
                    mirror_reg <= hmirror;
                    xs_reg     <= xscale;
                end
            end else if (state_reg == ACTIVE && pix_en) begin
                if (sx_reg != scale_last(xs_reg)) begin
                    sx_reg <= sx_reg + 1'b1;
                end else begin
                    sx_reg <= '0;
                    if (x_reg != x_end) begin
                        x_reg <= mirror_reg ? x_reg - 1'b1 : x_reg + 1'b1;
                    end else begin
                        state_reg <= IDLE;
                        if (sy_reg != scale_last(ys_reg)) begin
                            sy_reg <= sy_reg + 1'b1;
                        end else begin
                            sy_reg <= '0;
                            ys_reg <= yscale;
                            if (y_reg == Y_LAST) begin
                                y_reg          <= '0;
                                frame_done_reg <= 1'b1;
                            end else begin
                                y_reg <= y_reg + 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    assign load_ready   = (state_reg == LOAD);
    assign load_done    = load_done_reg;
    assign pixel_vld_o  = (state_reg == ACTIVE);
    assign pixel_o      = (state_reg == ACTIVE) ? rd_pixel : '0;
    assign frame_done_o = frame_done_reg;

endmodule

// File: tb/tb_sprite_stream.sv
// Randomized self-checking bench for sprite_stream against a line/frame level reference model.
module tb_sprite_stream;

    localparam int W     = 12;
    localparam int H     = 12;
    localparam int BPP   = 2;
    localparam int NPIX  = W * H;
    localparam int NBITS = NPIX * BPP;

    function automatic logic [NBITS-1:0] make_checker();
        logic [NBITS-1:0] v;
        v = '0;
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++)
                v[(yy*W+xx)*BPP +: BPP] = BPP'((xx + yy) % 2);
        return v;
    endfunction

    localparam logic [NBITS-1:0] INIT_BMP = make_checker();

    logic           gclk        = 1'b0;
    logic           rst_ni      = 1'b0;
    logic           pix_en      = 1'b0;
    logic           line_start  = 1'b0;
    logic           frame_start = 1'b0;
    logic           hmirror     = 1'b0;
    logic [1:0]     xscale      = 2'd0;
    logic [1:0]     yscale      = 2'd0;
    logic           load_start  = 1'b0;
    logic           load_valid  = 1'b0;
    logic [BPP-1:0] load_data   = '0;
    logic           load_ready;
    logic           load_done;
    logic [BPP-1:0] pixel_o;
    logic           pixel_vld_o;
    logic           frame_done_o;

    sprite_stream #(
        .WIDTH  (W),
        .HEIGHT (H),
        .BPP    (BPP),
        .INIT   (INIT_BMP)
    ) dut (
        .gclk         (gclk),
        .rst_ni       (rst_ni),
        .pix_en       (pix_en),
        .line_start   (line_start),
        .frame_start  (frame_start),
        .hmirror      (hmirror),
        .xscale       (xscale),
        .yscale       (yscale),
        .load_start   (load_start),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_ready   (load_ready),
        .load_done    (load_done),
        .pixel_o      (pixel_o),
        .pixel_vld_o  (pixel_vld_o),
        .frame_done_o (frame_done_o)
    );

    always #5 gclk = ~gclk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: bitmap as a 2-D array plus the row/repeat position in the frame.
    int model_bmp [H][W];
    int model_y, model_sy, model_ys;
    bit cur_m;
    int cur_xs, cur_beat;
    int frame_pulses;

    task automatic tick();
        @(posedge gclk);
        #1;
    endtask

    task automatic model_reset();
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++)
                model_bmp[yy][xx] = (xx + yy) % 2;
        model_y  = 0;
        model_sy = 0;
        model_ys = 0;
    endtask

    function automatic int exp_pixel(input int beat);
        int xi, xx;
        xi = beat >> cur_xs;
        xx = cur_m ? (W - 1 - xi) : xi;
        return model_bmp[model_y][xx];
    endfunction

    task automatic do_frame_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        model_y  = 0;
        model_sy = 0;
        model_ys = int'(yscale);
    endtask

    task automatic do_line_start(input bit fs, input bit m, input int xs);
        frame_start = fs;
        hmirror     = m;
        xscale      = 2'(xs);
        line_start  = 1'b1;
        tick();
        line_start  = 1'b0;
        frame_start = 1'b0;
        hmirror     = 1'($urandom);
        xscale      = 2'($urandom);
        if (fs) begin
            model_y  = 0;
            model_sy = 0;
            model_ys = int'(yscale);
        end
        cur_m    = m;
        cur_xs   = xs;
        cur_beat = 0;
        n_checks++;
        if (pixel_vld_o !== 1'b1) begin
            n_errors++;
            $display("FAIL line_start_vld: got pixel_vld_o=%b expected 1", pixel_vld_o);
        end
    endtask

    task automatic do_beats(input int n);
        for (int i = 0; i < n; i++) begin
            int e;
            e = exp_pixel(cur_beat);
            if ($urandom_range(0, 3) == 0) begin
                pix_en = 1'b0;
                tick();
            end
            n_checks++;
            if (pixel_o !== BPP'(e) || pixel_vld_o !== 1'b1) begin
                n_errors++;
                $display("FAIL beat_pixel: row=%0d beat=%0d got pixel=%0d vld=%b expected pixel=%0d vld=1",
                         model_y, cur_beat, pixel_o, pixel_vld_o, e);
            end
            pix_en = 1'b1;
            tick();
            pix_en = 1'b0;
            cur_beat++;
        end
    endtask

    task automatic end_line();
        bit exp_fd;
        int row;
        row    = model_y;
        exp_fd = 1'b0;
        n_checks++;
        if (pixel_vld_o !== 1'b0 || pixel_o !== '0) begin
            n_errors++;
            $display("FAIL line_end_idle: got vld=%b pixel=%0d expected vld=0 pixel=0", pixel_vld_o, pixel_o);
        end
        model_sy++;
        if (model_sy == (1 << model_ys)) begin
            model_sy = 0;
            model_ys = int'(yscale);
            if (model_y == H - 1) begin
                model_y = 0;
                exp_fd  = 1'b1;
            end else begin
                model_y++;
            end
        end
        n_checks++;
        if (frame_done_o !== exp_fd) begin
            n_errors++;
            $display("FAIL frame_done: got %b expected %b", frame_done_o, exp_fd);
        end
        if (frame_done_o === 1'b1) frame_pulses++;
        $display("line row=%0d mirror=%0d xs=%0d frame_done=%b", row, cur_m, cur_xs, frame_done_o);
        tick();
        n_checks++;
        if (frame_done_o !== 1'b0) begin
            n_errors++;
            $display("FAIL frame_done_width: got %b expected 0", frame_done_o);
        end
    endtask

    task automatic run_line(input bit fs, input bit m, input int xs);
        do_line_start(fs, m, xs);
        do_beats(W << xs);
        end_line();
    endtask

    // mode 0: data = index mod 4; mode 1: random data. Stops after n beats.
    task automatic do_load(input int n, input int mode);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        n_checks++;
        if (load_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL load_ready_enter: got %b expected 1", load_ready);
        end
        for (int i = 0; i < n; i++) begin
            int d;
            while ($urandom_range(0, 2) == 0) begin
                load_valid = 1'b0;
                load_data  = BPP'($urandom);
                tick();
            end
            d = (mode == 0) ? (i % 4) : int'($urandom_range(0, (1 << BPP) - 1));
            n_checks++;
            if (load_ready !== 1'b1 || load_done !== 1'b0) begin
                n_errors++;
                $display("FAIL load_beat_status: beat=%0d got ready=%b done=%b expected ready=1 done=0",
                         i, load_ready, load_done);
            end
            load_valid = 1'b1;
            load_data  = BPP'(d);
            tick();
            load_valid = 1'b0;
            model_bmp[i / W][i % W] = d;
        end
        if (n == NPIX) begin
            model_y  = 0;
            model_sy = 0;
            n_checks++;
            if (load_done !== 1'b1 || load_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL load_done_pulse: got done=%b ready=%b expected done=1 ready=0", load_done, load_ready);
            end
            tick();
            n_checks++;
            if (load_done !== 1'b0) begin
                n_errors++;
                $display("FAIL load_done_width: got %b expected 0", load_done);
            end
        end
        $display("load beats=%0d mode=%0d", n, mode);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({load_ready, load_done, pixel_o, pixel_vld_o, frame_done_o} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got ready=%b done=%b pixel=%0d vld=%b fd=%b expected all 0",
                     load_ready, load_done, pixel_o, pixel_vld_o, frame_done_o);
        end
        rst_ni = 1'b1;
        model_reset();
        tick();
        $display("reset released");
    endtask

    task automatic test_basic_line();
        yscale = 2'd0;
        run_line(1'b0, 1'b0, 0);
    endtask

    task automatic test_mirror_scale();
        yscale = 2'd2;
        run_line(1'b1, 1'b1, 1);
        for (int i = 0; i < 4; i++) run_line(1'b0, 1'($urandom), int'($urandom_range(0, 3)));
    endtask

    task automatic test_full_frame();
        yscale = 2'd0;
        do_frame_start();
        frame_pulses = 0;
        for (int i = 0; i < H; i++) run_line(1'b0, 1'($urandom), int'($urandom_range(0, 1)));
        n_checks++;
        if (frame_pulses != 1) begin
            n_errors++;
            $display("FAIL frame_pulse_count: got %0d expected 1", frame_pulses);
        end
        run_line(1'b0, 1'b0, 0);
    endtask

    task automatic test_load_mod4();
        do_load(NPIX, 0);
        for (int i = 0; i < 3; i++) run_line(1'b0, 1'($urandom), int'($urandom_range(0, 2)));
    endtask

    task automatic test_load_random();
        yscale = 2'd1;
        do_load(NPIX, 1);
        for (int i = 0; i < 6; i++) run_line(1'b0, 1'($urandom), int'($urandom_range(0, 1)));
    endtask

    task automatic test_restart();
        yscale = 2'd0;
        do_frame_start();
        run_line(1'b0, 1'b0, 0);
        do_line_start(1'b0, 1'b0, 0);
        do_beats(5);
        do_line_start(1'b0, 1'b0, 0);
        do_beats(W);
        end_line();
        run_line(1'b0, 1'b1, 0);
    endtask

    task automatic test_reset_mid_load();
        yscale = 2'd0;
        do_load(70, 1);
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if ({load_ready, load_done, pixel_o, pixel_vld_o, frame_done_o} !== '0) begin
            n_errors++;
            $display("FAIL midload_reset_outputs: got ready=%b done=%b pixel=%0d vld=%b fd=%b expected all 0",
                     load_ready, load_done, pixel_o, pixel_vld_o, frame_done_o);
        end
        repeat (2) tick();
        rst_ni = 1'b1;
        model_reset();
        tick();
        n_checks++;
        if (load_ready !== 1'b0 || pixel_vld_o !== 1'b0) begin
            n_errors++;
            $display("FAIL midload_reset_state: got ready=%b vld=%b expected 0 0", load_ready, pixel_vld_o);
        end
        for (int i = 0; i < 3; i++) run_line(1'b0, 1'($urandom), 0);
    endtask

    initial begin
        test_reset();
        test_basic_line();
        test_mirror_scale();
        test_full_frame();
        test_load_mod4();
        test_load_random();
        test_restart();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
